// File: rtl/mlaccel_memarb.sv
// mlaccel_memarb: N-client arbiter onto the single-port main memory, with a read-return pipeline.
// Define MLACCEL_MEMARB_RR_EN for round-robin arbitration; default build is fixed priority (client 0 highest).
module mlaccel_memarb #(
    parameter int NUM_CLIENTS  = 3,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic [NUM_CLIENTS-1:0]                req_valid,
    output logic [NUM_CLIENTS-1:0]                req_ready,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_CLIENTS*(DATA_WIDTH/8)-1:0] req_wen,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_CLIENTS-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]                 rsp_data,
    output logic                                  busy,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [DATA_WIDTH/8-1:0]               mem_wen,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(NUM_CLIENTS);

    // Handshake: a transfer happens in any cycle where req_valid[i] && req_ready[i]; a client
    // keeps addr/wen/wdata stable while valid and not ready, and ready never depends on state
    // other than the arbitration pointer, so at most one client is accepted per cycle.
    logic                    gnt_any;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    rd_accept;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_vld_d;
    logic [IDX_W-1:0]        pipe_own_q [READ_LATENCY];
    logic [IDX_W-1:0]        pipe_own_d [READ_LATENCY];

`ifdef MLACCEL_MEMARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W:0]   cand;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        // Offsets are walked farthest-first so the valid client nearest the pointer is the last writer.
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_CLIENTS)) begin
                cand = cand - (IDX_W+1)'(NUM_CLIENTS);
            end
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (req_valid[i] && cand == (IDX_W+1)'(i)) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        // Highest index first so the lowest-index valid client overrides.
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        mem_addr  = '0;
        mem_wen   = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (gnt_any && gnt_idx == IDX_W'(i)) begin
                req_ready[i] = 1'b1;
                mem_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wen      = req_wen[i*BE_WIDTH +: BE_WIDTH];
                mem_wdata    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_accept = gnt_any && (mem_wen == '0);

    // Owner tags travel alongside the memory's own read pipeline and exit with the data.
    always_comb begin
        pipe_vld_d = '0;
        for (int s = 0; s < READ_LATENCY; s++) begin
            pipe_own_d[s] = '0;
        end
        pipe_vld_d[0] = rd_accept;
        pipe_own_d[0] = gnt_idx;
        for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_own_d[s] = pipe_own_q[s-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
        end
        for (int s = 0; s < READ_LATENCY; s++) begin
            pipe_own_q[s] <= pipe_own_d[s];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (pipe_vld_q[READ_LATENCY-1] && pipe_own_q[READ_LATENCY-1] == IDX_W'(i)) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_data = mem_rdata;
    assign busy     = (|req_valid) | (|pipe_vld_q);

endmodule

// File: doc/mlaccel_memarb.md
# mlaccel_memarb

Parametrised arbiter that multiplexes N request clients onto the single-port main memory (`mlaccel_memory`). It generalises the fixed three-way memory mux in `mlaccel_top` (compute, QPI, sequencer) to any client count, memory width and read latency, and returns each read to its owner via a latency-tracking pipeline. It sits between the command, sequencer and compute blocks and the memory instance in `mlaccel_top`.

## Interface
- `NUM_CLIENTS`, 3: number of request clients, 2..8; client 0 has highest fixed priority.
- `ADDR_WIDTH`, 16: memory word address width.
- `DATA_WIDTH`, 64: memory data width; multiple of 8.
- `READ_LATENCY`, 1: cycles from address on `mem_addr` to valid `mem_rdata`; 1..4.
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_CLIENTS  per-client request.
- `req_ready`  out  NUM_CLIENTS  per-client grant/accept, one-hot or zero.
- `req_addr`  in  NUM_CLIENTS*ADDR_WIDTH  flattened addresses, client i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wen`  in  NUM_CLIENTS*DATA_WIDTH/8  flattened byte write enables; all-zero means read.
- `req_wdata`  in  NUM_CLIENTS*DATA_WIDTH  flattened write data.
- `rsp_valid`  out  NUM_CLIENTS  read-data strobe to the owning client.
- `rsp_data`  out  DATA_WIDTH  read data, shared by all clients.
- `busy`  out  1  any request pending or any read in flight.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wen`  out  DATA_WIDTH/8  memory byte write enables.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data.

## Operation
- Each cycle at most one client is granted; grant is combinational from `req_valid` and the arbitration state. `req_ready[i]` is high only for the granted client.
- Transfer occurs when `req_valid[i] && req_ready[i]`; clients hold addr/wen/wdata stable while valid and not ready.
- Granted client's addr/wen/wdata drive `mem_*` in the same cycle. No grant: `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
- Write (`req_wen`≠0): single cycle, no response.
- Read (`req_wen`=0): owner index and valid bit enter a shift register of depth `READ_LATENCY`; on exit `rsp_valid[owner]` pulses high for one cycle.
- `rsp_data` = `mem_rdata` (combinational pass-through); only meaningful where some `rsp_valid` bit is high.
- Back-to-back reads from any mix of clients are accepted every cycle; responses return in issue order, never merged or dropped.
- `busy` = `|req_valid` OR any valid bit in the latency pipeline.
- Fixed-priority mode: lowest-index valid client wins.

## Timing
- Reset (`resetn` low at a rising edge): latency pipeline cleared, round-robin pointer = 0. Next cycle `rsp_valid`=0, `busy` = `|req_valid`. `req_ready` and `mem_*` remain combinational and are not gated by reset.
- A read accepted at cycle t gives `rsp_valid` high at cycle t+`READ_LATENCY` and `rsp_data` valid in that same cycle.
- A response to client i can coincide with a new grant to client i; both are honoured.
- Reset asserted while reads are in flight: those responses are discarded and never signalled.
- Write then read of the same address in consecutive cycles: the read returns the new data. Memory write-first ordering is relied on.

## Configuration
- `MLACCEL_MEMARB_RR_EN` defined: round-robin arbitration. The search starts at the pointer and wraps modulo `NUM_CLIENTS`. After each accepted transfer the pointer is set to granted+1, wrapping to 0 after `NUM_CLIENTS`-1. The pointer is unchanged on idle cycles.
- Undefined: fixed priority, client 0 highest. No pointer register is present.

## Test plan
- Single read, READ_LATENCY=2: client 1 reads addr 0x0010 holding 0x1122334455667788 at cycle 5 -> `rsp_valid`=3'b010 at cycle 7, `rsp_data`=0x1122334455667788, `busy` low at cycle 8.
- Contention, fixed priority: clients 0 and 2 both valid for 4 cycles -> client 0 gets 4 consecutive grants, then client 2; `req_ready` is never multi-hot.
- Contention, `MLACCEL_MEMARB_RR_EN`, 3 clients all continuously valid -> grant sequence 0,1,2,0,1,2.
- Pipelined reads, READ_LATENCY=3: clients 2,0,1 read in cycles 10,11,12 -> `rsp_valid` = 3'b100, 3'b001, 3'b010 in cycles 13,14,15 with matching data.
- Write/read: client 0 writes 0xDEADBEEF with `mem_wen`=8'h0F to addr 0x00FF, client 1 reads 0x00FF next cycle -> `rsp_data[31:0]`=0xDEADBEEF with upper bytes unchanged.
- Reset mid-flight: read accepted, `resetn` low the next cycle -> no `rsp_valid` pulse; `busy`=0 after reset with no requests.
